// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared core widths and NZCV flag bit indices
package core_pkg;

   localparam int DATA_W    = 16;
   localparam int NUM_REGS  = 16;
   localparam int ADDR_W    = 4;

   // Bit positions inside the 4-bit {N,Z,C,V} status word
   localparam int NUM_FLAGS = 4;
   localparam int FLAG_N    = 3;
   localparam int FLAG_Z    = 2;
   localparam int FLAG_C    = 1;
   localparam int FLAG_V    = 0;

   typedef logic [NUM_FLAGS-1:0] flags_t;

endpackage

// File: rtl/reg_file_flags_flag_reg.sv
// rtl/reg_file_flags_flag_reg.sv - enabled NZCV status register with async clear
module flag_reg
   import core_pkg::*;
(
   input  logic   i_clk,
   input  logic   i_rst_n,
   input  logic   i_en,
   input  flags_t i_d,
   output flags_t o_q
);

   flags_t r_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_q <= '0;
      end else if (i_en) begin
         r_q <= i_d;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/reg_file_flags.sv
// rtl/reg_file_flags.sv - register file with R0 hardwired to zero plus NZCV capture
module reg_file_flags #(
   parameter int DATA_W   = core_pkg::DATA_W,
   parameter int NUM_REGS = core_pkg::NUM_REGS,
   parameter int ADDR_W   = core_pkg::ADDR_W
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rd_addr1,
   input  logic [ADDR_W-1:0] rd_addr2,
   output logic [DATA_W-1:0] read_data1,
   output logic [DATA_W-1:0] read_data2,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              flag_we,
   input  logic              n_in,
   input  logic              z_in,
   input  logic              c_in,
   input  logic              v_in,
   output logic [3:0]        flags,
   input  logic [ADDR_W-1:0] dbg_addr,
   output logic [DATA_W-1:0] dbg_data
);

   import core_pkg::*;

   logic [DATA_W-1:0] r_regs [NUM_REGS];
   flags_t            w_flags_d;
   flags_t            w_flags_q;

   // Slot 0 is never written, so it stays at its reset value of zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            r_regs[i] <= '0;
         end
      end else if (wr_en && (wr_addr != '0) && (int'(wr_addr) < NUM_REGS)) begin
         r_regs[wr_addr] <= wr_data;
      end
   end

   // No write bypass: wr_data is derived from these outputs in the same cycle
   function automatic logic [DATA_W-1:0] f_read(input logic [ADDR_W-1:0] a);
      if ((a == '0) || (int'(a) >= NUM_REGS)) begin
         return '0;
      end
      return r_regs[a];
   endfunction

   assign read_data1 = f_read(rd_addr1);
   assign read_data2 = f_read(rd_addr2);
   assign dbg_data   = f_read(dbg_addr);

   always_comb begin
      w_flags_d         = '0;
      w_flags_d[FLAG_N] = n_in;
      w_flags_d[FLAG_Z] = z_in;
      w_flags_d[FLAG_C] = c_in;
      w_flags_d[FLAG_V] = v_in;
   end

   flag_reg u_flag_reg (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_en    (flag_we),
      .i_d     (w_flags_d),
      .o_q     (w_flags_q)
   );

   assign flags = w_flags_q;

endmodule

// File: tb/tb_reg_file_flags.sv
// tb/tb_reg_file_flags.sv - scoreboard bench for reg_file_flags
module tb_reg_file_flags;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [3:0]  rd_addr1, rd_addr2, wr_addr, dbg_addr;
   logic [15:0] read_data1, read_data2, wr_data, dbg_data;
   logic        wr_en, flag_we, n_in, z_in, c_in, v_in;
   logic [3:0]  flags;

   typedef struct {
      int          sel;
      logic [15:0] exp;
      string       name;
   } exp_t;

   localparam int SEL_RD1 = 0, SEL_RD2 = 1, SEL_DBG = 2, SEL_FLG = 3;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   event sample_ev;

   always #5 clk = ~clk;

   reg_file_flags dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .rd_addr1   (rd_addr1),
      .rd_addr2   (rd_addr2),
      .read_data1 (read_data1),
      .read_data2 (read_data2),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .flag_we    (flag_we),
      .n_in       (n_in),
      .z_in       (z_in),
      .c_in       (c_in),
      .v_in       (v_in),
      .flags      (flags),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data)
   );

   task automatic expect_val(input int sel, input logic [15:0] exp, input string name);
      exp_t e;
      e.sel  = sel;
      e.exp  = exp;
      e.name = name;
      q.push_back(e);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   // Monitor: outputs are sampled on the falling edge, or on demand between edges
   initial begin
      forever begin
         @(negedge clk or sample_ev);
         while (q.size() > 0) begin
            exp_t        e;
            logic [15:0] act;
            e = q.pop_front();
            case (e.sel)
               SEL_RD1: act = read_data1;
               SEL_RD2: act = read_data2;
               SEL_DBG: act = dbg_data;
               default: act = {12'h000, flags};
            endcase
            checks++;
            if (act !== e.exp) begin
               failures++;
               $display("FAIL %s actual=%h expected=%h", e.name, act, e.exp);
            end
         end
      end
   end

   initial begin
      int wait_cycles;
      rst_n = 1'b0; wr_en = 1'b1; wr_addr = 4'd3; wr_data = 16'hBEEF;
      rd_addr1 = 4'd3; rd_addr2 = 4'd0; dbg_addr = 4'd0;
      flag_we = 1'b1; {n_in, z_in, c_in, v_in} = 4'b1111;

      // Writes and flag captures are ignored while held in reset
      expect_val(SEL_RD1, 16'h0000, "reset_rd1");
      expect_val(SEL_FLG, 16'h0000, "reset_flags");
      for (int i = 0; i < 2; i++) begin
         next_cycle();
         expect_val(SEL_RD1, 16'h0000, "reset_rd1_clk");
         expect_val(SEL_FLG, 16'h0000, "reset_flags_clk");
      end

      next_cycle();
      rst_n = 1'b1; wr_en = 1'b0; flag_we = 1'b0;
      expect_val(SEL_RD1, 16'h0000, "post_reset_r3");
      expect_val(SEL_FLG, 16'h0000, "post_reset_flags");

      next_cycle();
      wr_en = 1'b1; wr_addr = 4'd5; wr_data = 16'h00F0;
      rd_addr1 = 4'd5; rd_addr2 = 4'd5;
      expect_val(SEL_RD1, 16'h0000, "r5_old_rd1");
      expect_val(SEL_RD2, 16'h0000, "r5_old_rd2");

      next_cycle();
      wr_en = 1'b1; wr_addr = 4'd0; wr_data = 16'hFFFF;
      expect_val(SEL_RD1, 16'h00F0, "r5_new_rd1");
      expect_val(SEL_RD2, 16'h00F0, "r5_new_rd2");

      next_cycle();
      wr_en = 1'b0; rd_addr1 = 4'd0; dbg_addr = 4'd0; rd_addr2 = 4'd5;
      expect_val(SEL_RD1, 16'h0000, "r0_rd1");
      expect_val(SEL_DBG, 16'h0000, "r0_dbg");
      expect_val(SEL_RD2, 16'h00F0, "r5_kept");

      flag_we = 1'b1; {n_in, z_in, c_in, v_in} = 4'b1010;
      expect_val(SEL_FLG, 16'h0000, "flags_before_capture");
      next_cycle();
      flag_we = 1'b0; {n_in, z_in, c_in, v_in} = 4'b0101;
      expect_val(SEL_FLG, 16'h000A, "flags_captured");
      next_cycle();
      expect_val(SEL_FLG, 16'h000A, "flags_hold");

      wr_en = 1'b1; wr_addr = 4'd7; wr_data = 16'h8001;
      flag_we = 1'b1; {n_in, z_in, c_in, v_in} = 4'b0110;
      rd_addr1 = 4'd7; rd_addr2 = 4'd7; dbg_addr = 4'd7;
      next_cycle();
      wr_en = 1'b1; wr_addr = 4'd15; wr_data = 16'h1234; flag_we = 1'b0;
      expect_val(SEL_RD1, 16'h8001, "r7_rd1");
      expect_val(SEL_RD2, 16'h8001, "r7_rd2");
      expect_val(SEL_DBG, 16'h8001, "r7_dbg");
      expect_val(SEL_FLG, 16'h0006, "flags_same_edge");

      next_cycle();
      wr_en = 1'b0; dbg_addr = 4'd15; rd_addr1 = 4'd5;
      expect_val(SEL_DBG, 16'h1234, "r15_dbg");
      expect_val(SEL_RD1, 16'h00F0, "r5_after_r15");

      // Drop reset between edges and sample before the next rising edge
      next_cycle();
      rd_addr1 = 4'd5; rd_addr2 = 4'd7; dbg_addr = 4'd15;
      expect_val(SEL_RD1, 16'h00F0, "pre_drop_rd1");
      expect_val(SEL_RD2, 16'h8001, "pre_drop_rd2");
      #6;
      rst_n = 1'b0;
      #1;
      expect_val(SEL_RD1, 16'h0000, "async_rd1");
      expect_val(SEL_RD2, 16'h0000, "async_rd2");
      expect_val(SEL_DBG, 16'h0000, "async_dbg");
      expect_val(SEL_FLG, 16'h0000, "async_flags");
      -> sample_ev;
      #1;

      wait_cycles = 0;
      while (q.size() > 0 && wait_cycles < 10) begin
         @(posedge clk);
         wait_cycles++;
      end
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain actual=%0d expected=0", q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
